icache_nway_sync: RTL and testbench

Parametrised, single-clock, N-way set-associative instruction cache. It is the synchronous successor to the two-way click-driven Icache, and sits between the instruction fetch unit (IFU) and the L2 cache. It adds:
- configurable ways, sets and line size;
- valid/ready handshakes on every port;
- an automatic invalidate sweep after reset and on flush;
- invalid-first, per-set round-robin replacement;
- saturating hit and miss counters.

---
 rtl/icache_nway_sync.sv | 204 ++++++++++++++++++++
 tb/tb_icache_nway_sync.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway_sync.sv
// icache_nway_sync: N-way set-associative instruction cache sitting between the
// instruction fetch unit and L2. Single clock, synchronous active-low reset,
// valid/ready handshakes, invalidate sweep after reset and flush, invalid-first
// round-robin replacement and saturating hit/miss statistics.
module icache_nway_sync #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 32,
    parameter int PA_W       = 34
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [PA_W-1:0]         req_pa,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*LINE_BYTES-1:0] resp_data,
    output logic                    resp_hit,
    output logic                    l2_req_valid,
    input  logic                    l2_req_ready,
    output logic [PA_W-1:0]         l2_req_addr,
    input  logic                    l2_rsp_valid,
    input  logic [8*LINE_BYTES-1:0] l2_rsp_data,
    input  logic                    flush_i,
    output logic                    busy,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = PA_W - IDX_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [PA_W-1:0] OFF_MASK = PA_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP
    } state_t;

    state_t state, state_next;

    logic [WAYS-1:0]   valid_mem [SETS];
    logic [WAY_W-1:0]  ptr_mem   [SETS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [LINE_W-1:0] data_mem  [SETS][WAYS];

    logic [IDX_W-1:0]  init_idx;
    logic              flush_pending;
    logic [PA_W-1:0]   lat_pa;
    logic [WAYS-1:0]   rd_valid;
    logic [WAY_W-1:0]  rd_ptr;
    logic [TAG_W-1:0]  rd_tag  [WAYS];
    logic [LINE_W-1:0] rd_data [WAYS];
    logic [WAY_W-1:0]  vic_way;
    logic              vic_from_ptr;

    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic [IDX_W-1:0]  req_idx;
    logic              accept;
    logic              refill_fire;
    logic              lookup_hit;
    logic [WAY_W-1:0]  hit_way;
    logic              has_invalid;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  ptr_next;

    assign lat_tag     = lat_pa[PA_W-1:IDX_W+OFF_W];
    assign lat_idx     = lat_pa[IDX_W+OFF_W-1:OFF_W];
    assign req_idx     = req_pa[IDX_W+OFF_W-1:OFF_W];
    assign accept      = (state == IDLE) && (state_next == LOOKUP);
    assign refill_fire = (state == MISS_WAIT) && l2_rsp_valid;
    assign ptr_next    = (WAYS > 1) ? vic_way + WAY_W'(1) : '0;

    // Status outputs decode straight from the state register, so no input reaches them.
    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign l2_req_valid = (state == MISS_REQ);
    assign busy         = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= INIT;
        else       state <= state_next;
    end

    // Next-state logic; a flush (live or pending) wins over a request in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            INIT:      if (init_idx == IDX_W'(SETS - 1)) state_next = IDLE;
            IDLE: begin
                if (flush_i || flush_pending) state_next = INIT;
                else if (req_valid)           state_next = LOOKUP;
            end
            LOOKUP:    state_next = lookup_hit ? RESP : MISS_REQ;
            MISS_REQ:  if (l2_req_ready) state_next = MISS_WAIT;
            MISS_WAIT: if (l2_rsp_valid) state_next = RESP;
            RESP:      if (resp_ready)   state_next = IDLE;
            default:   state_next = INIT;
        endcase
    end

    // Tag compare across the ways; scanning downward lets the lowest way win.
    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_tag[w] == lat_tag)) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest invalid way first, otherwise the set's round-robin pointer.
    always_comb begin
        has_invalid = 1'b0;
        victim      = rd_ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!rd_valid[w]) begin
                has_invalid = 1'b1;
                victim      = WAY_W'(w);
            end
        end
    end

    // Synchronous array read on acceptance, and victim capture during LOOKUP.
    always_ff @(posedge clk) begin
        if (rstn && accept) begin
            lat_pa   <= req_pa;
            rd_valid <= valid_mem[req_idx];
            rd_ptr   <= ptr_mem[req_idx];
            for (int w = 0; w < WAYS; w++) begin
                rd_tag[w]  <= tag_mem[req_idx][w];
                rd_data[w] <= data_mem[req_idx][w];
            end
        end
        if (state == LOOKUP) begin
            vic_way      <= victim;
            vic_from_ptr <= !has_invalid;
        end
    end

    // Valid bits and pointers: cleared one set per cycle in INIT, updated on refill.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (state == INIT) begin
                valid_mem[init_idx] <= '0;
                ptr_mem[init_idx]   <= '0;
            end else if (refill_fire) begin
                valid_mem[lat_idx][vic_way] <= 1'b1;
                if (vic_from_ptr) ptr_mem[lat_idx] <= ptr_next;
            end
        end
    end

    // Tag and data write into the victim way when the refill arrives.
    always_ff @(posedge clk) begin
        if (rstn && refill_fire) begin
            tag_mem[lat_idx][vic_way]  <= lat_tag;
            data_mem[lat_idx][vic_way] <= l2_rsp_data;
        end
    end

    // Sweep index and deferred-flush flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            init_idx      <= '0;
            flush_pending <= 1'b0;
        end else begin
            init_idx <= (state == INIT) ? init_idx + 1'b1 : '0;
            if ((state == IDLE) && (state_next == INIT)) flush_pending <= 1'b0;
            else if (flush_i && (state != IDLE))         flush_pending <= 1'b1;
        end
    end

    // Response, L2 address and saturating statistics registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_data   <= '0;
            resp_hit    <= 1'b0;
            l2_req_addr <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            if (state == LOOKUP) begin
                if (lookup_hit) begin
                    resp_data <= rd_data[hit_way];
                    resp_hit  <= 1'b1;
                    if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    l2_req_addr <= lat_pa & ~OFF_MASK;
                    if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                end
            end
            if (refill_fire) begin
                resp_data <= l2_rsp_data;
                resp_hit  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_icache_nway_sync.sv
// tb_icache_nway_sync: scenario tasks for icache_nway_sync, checked against a
// FIFO-per-set behavioural cache model kept in the bench.
module tb_icache_nway_sync;
    localparam int WAYS       = 2;
    localparam int SETS       = 128;
    localparam int LINE_BYTES = 32;
    localparam int PA_W       = 34;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(SETS);
    localparam int TAG_W      = PA_W - IDX_W - OFF_W;
    localparam int LINE_W     = 8 * LINE_BYTES;

    logic              clk;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [PA_W-1:0]   req_pa;
    logic              resp_valid;
    logic              resp_ready;
    logic [LINE_W-1:0] resp_data;
    logic              resp_hit;
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [PA_W-1:0]   l2_req_addr;
    logic              l2_rsp_valid;
    logic [LINE_W-1:0] l2_rsp_data;
    logic              flush_i;
    logic              busy;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    int errors;
    int checks;

    icache_nway_sync #(
        .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES), .PA_W(PA_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_pa(req_pa),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_hit(resp_hit),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
        .l2_req_addr(l2_req_addr),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data),
        .flush_i(flush_i), .busy(busy),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each set holds its resident lines in fill order; a full set
    // evicts its oldest line, and hits leave the order untouched.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } mline_t;

    mline_t model_q[$];
    int     model_hits;
    int     model_misses;

    function automatic void model_clear_lines();
        model_q.delete();
    endfunction

    function automatic void model_access(input logic [PA_W-1:0] pa, input logic [LINE_W-1:0] fill,
                                         output logic hit, output logic [LINE_W-1:0] data);
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        int count;
        int first;
        idx  = pa[IDX_W+OFF_W-1:OFF_W];
        tag  = pa[PA_W-1:IDX_W+OFF_W];
        hit  = 1'b0;
        data = fill;
        foreach (model_q[i]) begin
            if (model_q[i].idx == idx && model_q[i].tag == tag) begin
                hit  = 1'b1;
                data = model_q[i].data;
            end
        end
        if (hit) begin
            model_hits++;
        end else begin
            model_misses++;
            count = 0;
            first = -1;
            foreach (model_q[i]) begin
                if (model_q[i].idx == idx) begin
                    count++;
                    if (first < 0) first = i;
                end
            end
            if (count >= WAYS) model_q.delete(first);
            model_q.push_back('{idx: idx, tag: tag, data: fill});
        end
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [PA_W-1:0] make_pa(input int unsigned tag, input int unsigned idx,
                                                 input int unsigned off);
        return {TAG_W'(tag), IDX_W'(idx), OFF_W'(off)};
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rstn = 1'b1;
        model_clear_lines();
        model_hits   = 0;
        model_misses = 0;
    endtask

    // Drives one complete fetch, acting as IFU and L2. lat counts edges from the
    // accept edge until resp_valid or l2_req_valid is seen.
    task automatic do_access(
        input  logic [PA_W-1:0]   pa,
        input  logic [LINE_W-1:0] fill,
        input  int                l2_stall,
        input  int                resp_stall,
        input  bit                flush_in_wait,
        output logic              got_hit,
        output logic [LINE_W-1:0] got_data,
        output logic [PA_W-1:0]   got_l2_addr,
        output int                lat,
        output bit                l2_stable,
        output bit                resp_stable,
        output bit                timeout);
        int n;
        timeout = 0; l2_stable = 1; resp_stable = 1; lat = 0;
        got_hit = 1'b0; got_data = '0; got_l2_addr = '0;
        n = 0;
        while (req_ready !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        if (req_ready !== 1'b1) begin timeout = 1; return; end
        req_pa = pa; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        do begin @(posedge clk); #1; lat++; end
        while (resp_valid !== 1'b1 && l2_req_valid !== 1'b1 && lat < 20);
        if (l2_req_valid === 1'b1) begin
            got_l2_addr = l2_req_addr;
            for (int i = 0; i < l2_stall; i++) begin
                @(posedge clk); #1;
                if (l2_req_valid !== 1'b1 || l2_req_addr !== got_l2_addr) l2_stable = 0;
            end
            l2_req_ready = 1'b1;
            @(posedge clk); #1;
            l2_req_ready = 1'b0;
            if (flush_in_wait) begin
                flush_i = 1'b1;
                @(posedge clk); #1;
                flush_i = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            l2_rsp_data = fill; l2_rsp_valid = 1'b1;
            @(posedge clk); #1;
            l2_rsp_valid = 1'b0; l2_rsp_data = '0;
        end
        if (resp_valid !== 1'b1) begin timeout = 1; return; end
        got_hit  = resp_hit;
        got_data = resp_data;
        for (int i = 0; i < resp_stall; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_data !== got_data || resp_hit !== got_hit ||
                req_ready !== 1'b0) resp_stable = 0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit hold_ok;
        rstn = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_ready: got %b expected 0", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 1", busy); end
        checks++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp: got valid=%b hit=%b expected 0/0", resp_valid, resp_hit); end
        checks++; if (resp_data !== '0) begin errors++; $display("[TB] FAIL rst_resp_data: got %h expected 0", resp_data); end
        checks++; if (l2_req_valid !== 1'b0 || l2_req_addr !== '0) begin errors++; $display("[TB] FAIL rst_l2: got valid=%b addr=%h expected 0/0", l2_req_valid, l2_req_addr); end
        checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("[TB] FAIL rst_counters: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
        rstn = 1'b1;
        model_clear_lines(); model_hits = 0; model_misses = 0;
        hold_ok = 1;
        for (int k = 1; k < SETS; k++) begin
            @(posedge clk); #1;
            if (req_ready !== 1'b0 || busy !== 1'b1) hold_ok = 0;
        end
        checks++; if (!hold_ok) begin errors++; $display("[TB] FAIL sweep_hold: got ready early expected ready=0 busy=1 for %0d cycles", SETS - 1); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL sweep_done: got ready=%b busy=%b expected 1/0", req_ready, busy); end
    endtask

    task automatic test_cold_miss_hit();
        logic [PA_W-1:0] pa; logic [LINE_W-1:0] d; logic h; logic [LINE_W-1:0] gd;
        logic [PA_W-1:0] ga; int lat; bit ls, rs, to; logic eh; logic [LINE_W-1:0] ed;
        pa = 34'h0_0000_1004;
        d  = rand_line();
        do_access(pa, d, 0, 0, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa, d, eh, ed);
        checks++; if (to) begin errors++; $display("[TB] FAIL cold_timeout: got timeout expected response"); end
        checks++; if (ga !== 34'h0_0000_1000) begin errors++; $display("[TB] FAIL cold_l2_addr: got %h expected 000001000", ga); end
        checks++; if (h !== 1'b0 || gd !== d) begin errors++; $display("[TB] FAIL cold_resp: got hit=%b data=%h expected hit=0 data=%h", h, gd, d); end
        do_access(pa, rand_line(), 0, 0, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa, d, eh, ed);
        checks++; if (to || h !== 1'b1) begin errors++; $display("[TB] FAIL warm_hit: got hit=%b timeout=%0d expected hit=1", h, to); end
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL warm_latency: got resp %0d edges after accept expected 1", lat); end
        checks++; if (gd !== d) begin errors++; $display("[TB] FAIL warm_data: got %h expected %h", gd, d); end
        checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin errors++; $display("[TB] FAIL warm_counters: got %0d/%0d expected 1/1", hit_cnt, miss_cnt); end
    endtask

    task automatic test_replacement();
        int unsigned tags[5];
        bit          exp_hit[5];
        logic h; logic [LINE_W-1:0] gd, d, ed; logic [PA_W-1:0] ga, pa; int lat; bit ls, rs, to; logic eh;
        tags    = '{32'h100, 32'h101, 32'h102, 32'h101, 32'h100};
        exp_hit = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            pa = make_pa(tags[i], 9, 0);
            d  = rand_line();
            do_access(pa, d, 0, 0, 0, h, gd, ga, lat, ls, rs, to);
            model_access(pa, d, eh, ed);
            checks++; if (to || h !== exp_hit[i]) begin errors++; $display("[TB] FAIL repl_hit_%0d: got hit=%b expected %b", i, h, exp_hit[i]); end
            checks++; if (gd !== ed) begin errors++; $display("[TB] FAIL repl_data_%0d: got %h expected %h", i, gd, ed); end
        end
    endtask

    task automatic test_backpressure();
        logic h; logic [LINE_W-1:0] gd, d, ed; logic [PA_W-1:0] ga, pa; int lat; bit ls, rs, to; logic eh;
        pa = make_pa(7, 20, 12);
        d  = rand_line();
        do_access(pa, d, 3, 5, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa, d, eh, ed);
        checks++; if (to) begin errors++; $display("[TB] FAIL bp_timeout: got timeout expected response"); end
        checks++; if (!ls) begin errors++; $display("[TB] FAIL bp_l2_stable: got changing l2 request expected stable %h", ga); end
        checks++; if (!rs) begin errors++; $display("[TB] FAIL bp_miss_resp_stable: got changing response expected stable"); end
        checks++; if (h !== eh || gd !== ed) begin errors++; $display("[TB] FAIL bp_miss_data: got %b/%h expected %b/%h", h, gd, eh, ed); end
        do_access(pa, rand_line(), 0, 5, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa, d, eh, ed);
        checks++; if (!rs || to) begin errors++; $display("[TB] FAIL bp_hit_resp_stable: got changing response expected stable"); end
        checks++; if (h !== eh || gd !== ed) begin errors++; $display("[TB] FAIL bp_hit_data: got %b/%h expected %b/%h", h, gd, eh, ed); end
    endtask

    task automatic test_flush_during_miss();
        logic h; logic [LINE_W-1:0] gd, d, ed; logic [PA_W-1:0] ga, pa_x, pa_y; int lat, n; bit ls, rs, to; logic eh;
        pa_x = make_pa(32'h33, 40, 0);
        pa_y = make_pa(32'h34, 41, 4);
        d = rand_line();
        do_access(pa_x, d, 0, 0, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa_x, d, eh, ed);
        do_access(pa_x, rand_line(), 0, 0, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa_x, d, eh, ed);
        checks++; if (h !== 1'b1 || gd !== ed) begin errors++; $display("[TB] FAIL flush_prehit: got %b/%h expected 1/%h", h, gd, ed); end
        d = rand_line();
        do_access(pa_y, d, 0, 0, 1, h, gd, ga, lat, ls, rs, to);
        model_access(pa_y, d, eh, ed);
        checks++; if (to || h !== 1'b0 || gd !== d) begin errors++; $display("[TB] FAIL flush_miss_completes: got %b/%h expected 0/%h", h, gd, d); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_enters_init: got busy=%b expected 1", busy); end
        n = 0;
        while (req_ready !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        checks++; if (n !== SETS) begin errors++; $display("[TB] FAIL flush_sweep_len: got %0d cycles expected %0d", n, SETS); end
        model_clear_lines();
        d = rand_line();
        do_access(pa_x, d, 0, 0, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa_x, d, eh, ed);
        checks++; if (to || h !== 1'b0 || gd !== d) begin errors++; $display("[TB] FAIL flush_evicted: got %b/%h expected 0/%h", h, gd, d); end
        checks++; if (hit_cnt !== 32'(model_hits) || miss_cnt !== 32'(model_misses)) begin errors++; $display("[TB] FAIL flush_counters: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, model_hits, model_misses); end
    endtask

    task automatic test_reset_during_miss();
        logic h; logic [LINE_W-1:0] gd, d, ed; logic [PA_W-1:0] ga, pa; int lat, n; bit ls, rs, to; logic eh; bit quiet;
        pa = make_pa(32'h55, 60, 0);
        n = 0;
        while (req_ready !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        req_pa = pa; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (l2_req_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (l2_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmiss_l2_req: got %b expected 1", l2_req_valid); end
        l2_req_ready = 1'b1;
        @(posedge clk); #1;
        l2_req_ready = 1'b0;
        rstn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rstn = 1'b1;
        model_clear_lines(); model_hits = 0; model_misses = 0;
        repeat (2) begin @(posedge clk); #1; end
        l2_rsp_data = rand_line(); l2_rsp_valid = 1'b1;
        @(posedge clk); #1;
        l2_rsp_valid = 1'b0; l2_rsp_data = '0;
        quiet = 1;
        repeat (6) begin
            if (resp_valid !== 1'b0) quiet = 0;
            @(posedge clk); #1;
        end
        checks++; if (!quiet) begin errors++; $display("[TB] FAIL rstmiss_no_resp: got resp_valid=1 expected 0"); end
        checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("[TB] FAIL rstmiss_counters: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
        d = rand_line();
        do_access(pa, d, 0, 0, 0, h, gd, ga, lat, ls, rs, to);
        model_access(pa, d, eh, ed);
        checks++; if (to || h !== 1'b0 || gd !== d) begin errors++; $display("[TB] FAIL rstmiss_absent: got %b/%h expected 0/%h", h, gd, d); end
        checks++; if (miss_cnt !== 32'd1) begin errors++; $display("[TB] FAIL rstmiss_miss_cnt: got %0d expected 1", miss_cnt); end
    endtask

    task automatic test_random();
        logic h; logic [LINE_W-1:0] gd, d, ed; logic [PA_W-1:0] ga, pa; int lat; bit ls, rs, to; logic eh;
        for (int i = 0; i < 80; i++) begin
            pa = make_pa($urandom_range(0, 3), $urandom_range(100, 103), $urandom_range(0, LINE_BYTES - 1));
            d  = rand_line();
            do_access(pa, d, $urandom_range(0, 2), $urandom_range(0, 2), 0, h, gd, ga, lat, ls, rs, to);
            model_access(pa, d, eh, ed);
            checks++; if (to) begin errors++; $display("[TB] FAIL rnd_timeout_%0d: got timeout expected response", i); end
            checks++; if (h !== eh || gd !== ed) begin errors++; $display("[TB] FAIL rnd_resp_%0d: got %b/%h expected %b/%h", i, h, gd, eh, ed); end
            checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL rnd_latency_%0d: got %0d expected 1", i, lat); end
            if (!eh) begin
                checks++; if (ga !== {pa[PA_W-1:OFF_W], {OFF_W{1'b0}}}) begin errors++; $display("[TB] FAIL rnd_l2_addr_%0d: got %h expected %h", i, ga, {pa[PA_W-1:OFF_W], {OFF_W{1'b0}}}); end
            end
        end
        checks++; if (hit_cnt !== 32'(model_hits) || miss_cnt !== 32'(model_misses)) begin errors++; $display("[TB] FAIL rnd_counters: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, model_hits, model_misses); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rstn = 1'b0; req_valid = 1'b0; req_pa = '0; resp_ready = 1'b0;
        l2_req_ready = 1'b0; l2_rsp_valid = 1'b0; l2_rsp_data = '0; flush_i = 1'b0;
        model_hits = 0; model_misses = 0;
        test_reset();
        test_cold_miss_hit();
        test_replacement();
        test_backpressure();
        test_flush_during_miss();
        test_reset_during_miss();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
